// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
//
// Purpose:
//   Pipeline control unit for an RV32 core. It decodes the ID-stage opcode into
//   a control bundle and carries that bundle through the ID/EX, EX/MEM and
//   MEM/WB registers. It detects load-use hazards, inserts a bubble while the
//   hazard lasts, and squashes the ID-stage instruction when a taken branch or
//   jump resolves in EX (flush).
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   id_valid            ID-stage instruction valid
//   id_opcode           instr[6:0]
//   id_rd/id_rs1/id_rs2 destination / source register indices
//   flush               kill the ID-stage instruction (has priority over stall)
//   stall               combinational load-use stall (hold PC and IF/ID)
//   ex_*                EX-stage control bundle
//   mem_*               MEM-stage control bundle
//   wb_*                WB-stage control bundle
//   stall_count         saturating count of stall cycles
//   illegal             sticky illegal-opcode flag
//
// Optional feature:
//   ILLEGAL_OPCODE_TRAP_EN - when defined, a valid unrecognised opcode that
//   enters EX sets the sticky 'illegal' flag. When undefined, 'illegal' is
//   tied 0 and unrecognised opcodes are silent NOPs.
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic                   ex_alusrc,
  output logic                   ex_jump,
  output logic                   ex_branch,
  output logic                   ex_memread,
  output logic                   ex_regwrite,
  output logic [ALUOP_W-1:0]     ex_aluop,
  output logic [REG_ADDR_W-1:0]  ex_rd,
  output logic                   mem_valid,
  output logic                   mem_memread,
  output logic                   mem_memwrite,
  output logic                   mem_regwrite,
  output logic                   mem_memtoreg,
  output logic [REG_ADDR_W-1:0]  mem_rd,
  output logic                   wb_valid,
  output logic                   wb_regwrite,
  output logic                   wb_memtoreg,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   illegal
);

  // Opcode encodings handled by the decoder
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [REG_ADDR_W-1:0]  RD_ZERO  = {REG_ADDR_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE  = STALL_CNT_W'(1);

  // ---------------------------------------------------------------------------
  // ID-stage decode signals
  // ---------------------------------------------------------------------------
  logic       dec_regwrite_s;
  logic       dec_memread_s;
  logic       dec_memwrite_s;
  logic       dec_memtoreg_s;
  logic       dec_alusrc_s;
  logic [1:0] dec_aluop_s;
  logic       dec_jump_s;
  logic       dec_branch_s;
  logic       dec_uses_rs1_s;
  logic       dec_uses_rs2_s;
  logic       dec_rw_eff_s;
  logic       stall_s;

  // ---------------------------------------------------------------------------
  // Pipeline registers and their next-state values
  // ---------------------------------------------------------------------------
  logic                  ex_valid_q,    ex_valid_d;
  logic                  ex_regwrite_q, ex_regwrite_d;
  logic                  ex_memread_q,  ex_memread_d;
  logic                  ex_memwrite_q, ex_memwrite_d;
  logic                  ex_memtoreg_q, ex_memtoreg_d;
  logic                  ex_alusrc_q,   ex_alusrc_d;
  logic                  ex_jump_q,     ex_jump_d;
  logic                  ex_branch_q,   ex_branch_d;
  logic [ALUOP_W-1:0]    ex_aluop_q,    ex_aluop_d;
  logic [REG_ADDR_W-1:0] ex_rd_q,       ex_rd_d;

  logic                  mem_valid_q;
  logic                  mem_memread_q;
  logic                  mem_memwrite_q;
  logic                  mem_regwrite_q;
  logic                  mem_memtoreg_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;

  logic                  wb_valid_q;
  logic                  wb_regwrite_q;
  logic                  wb_memtoreg_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  // Opcode decode into the control bundle; unrecognised opcodes decode as NOP
  always_comb begin
    dec_regwrite_s = 1'b0;
    dec_memread_s  = 1'b0;
    dec_memwrite_s = 1'b0;
    dec_memtoreg_s = 1'b0;
    dec_alusrc_s   = 1'b0;
    dec_aluop_s    = 2'b00;
    dec_jump_s     = 1'b0;
    dec_branch_s   = 1'b0;
    dec_uses_rs1_s = 1'b0;
    dec_uses_rs2_s = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec_regwrite_s = 1'b1;
        dec_aluop_s    = 2'b10;
        dec_uses_rs1_s = 1'b1;
        dec_uses_rs2_s = 1'b1;
      end
      OP_I: begin
        dec_regwrite_s = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_aluop_s    = 2'b10;
        dec_uses_rs1_s = 1'b1;
      end
      OP_LW: begin
        dec_regwrite_s = 1'b1;
        dec_memread_s  = 1'b1;
        dec_memtoreg_s = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_uses_rs1_s = 1'b1;
      end
      OP_SW: begin
        dec_memwrite_s = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_uses_rs1_s = 1'b1;
        dec_uses_rs2_s = 1'b1;
      end
      OP_BR: begin
        dec_branch_s   = 1'b1;
        dec_aluop_s    = 2'b01;
        dec_uses_rs1_s = 1'b1;
        dec_uses_rs2_s = 1'b1;
      end
      OP_JAL: begin
        dec_regwrite_s = 1'b1;
        dec_jump_s     = 1'b1;
      end
      OP_JALR: begin
        dec_regwrite_s = 1'b1;
        dec_jump_s     = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_uses_rs1_s = 1'b1;
      end
      OP_LUI: begin
        dec_regwrite_s = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_aluop_s    = 2'b11;
      end
      OP_AUIPC: begin
        dec_regwrite_s = 1'b1;
        dec_alusrc_s   = 1'b1;
      end
      default: begin
        dec_regwrite_s = 1'b0;
      end
    endcase
  end

  // x0 is hard-wired to zero, so a write to it is dropped at decode time
  assign dec_rw_eff_s = dec_regwrite_s & (id_rd != RD_ZERO);

  // Load-use hazard: the load in EX returns data too late for the ID consumer.
  // x0 never hazards, and a flushed ID instruction does not need to wait.
  assign stall_s = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != RD_ZERO) &
                   ((dec_uses_rs1_s & (id_rs1 == ex_rd_q)) |
                    (dec_uses_rs2_s & (id_rs2 == ex_rd_q))) &
                   ~flush;

  // ID/EX next state: bubble on flush, stall or invalid ID, else decoded bundle
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    ex_memwrite_d = 1'b0;
    ex_memtoreg_d = 1'b0;
    ex_alusrc_d   = 1'b0;
    ex_jump_d     = 1'b0;
    ex_branch_d   = 1'b0;
    ex_aluop_d    = {ALUOP_W{1'b0}};
    ex_rd_d       = RD_ZERO;
    if (!flush && !stall_s && id_valid) begin
      ex_valid_d    = 1'b1;
      ex_regwrite_d = dec_rw_eff_s;
      ex_memread_d  = dec_memread_s;
      ex_memwrite_d = dec_memwrite_s;
      ex_memtoreg_d = dec_memtoreg_s;
      ex_alusrc_d   = dec_alusrc_s;
      ex_jump_d     = dec_jump_s;
      ex_branch_d   = dec_branch_s;
      ex_aluop_d    = ALUOP_W'(dec_aluop_s);
      ex_rd_d       = id_rd;
    end else begin
      ex_valid_d    = 1'b0;
    end
  end

  // Saturating stall-cycle counter next state
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_s && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_memtoreg_q <= 1'b0;
      ex_alusrc_q   <= 1'b0;
      ex_jump_q     <= 1'b0;
      ex_branch_q   <= 1'b0;
      ex_aluop_q    <= {ALUOP_W{1'b0}};
      ex_rd_q       <= RD_ZERO;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_memtoreg_q <= ex_memtoreg_d;
      ex_alusrc_q   <= ex_alusrc_d;
      ex_jump_q     <= ex_jump_d;
      ex_branch_q   <= ex_branch_d;
      ex_aluop_q    <= ex_aluop_d;
      ex_rd_q       <= ex_rd_d;
    end
  end

  // EX/MEM and MEM/WB registers: advance every cycle, no backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_q    <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_rd_q       <= RD_ZERO;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_rd_q        <= RD_ZERO;
    end else begin
      mem_valid_q    <= ex_valid_q;
      mem_memread_q  <= ex_memread_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_rd_q       <= ex_rd_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  // Stall-cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= {STALL_CNT_W{1'b0}};
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic illegal_q, illegal_d;

  // True for every opcode the decoder recognises
  function automatic logic is_known_op(input logic [6:0] op);
    logic known;
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known = 1'b1;
      default:                           known = 1'b0;
    endcase
    return known;
  endfunction

  // Sticky flag: set when a valid unrecognised opcode actually enters EX
  always_comb begin
    illegal_d = illegal_q;
    if (id_valid && !flush && !stall_s && !is_known_op(id_opcode)) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Illegal-opcode flag register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign stall        = stall_s;
  assign ex_valid     = ex_valid_q;
  assign ex_alusrc    = ex_alusrc_q;
  assign ex_jump      = ex_jump_q;
  assign ex_branch    = ex_branch_q;
  assign ex_memread   = ex_memread_q;
  assign ex_regwrite  = ex_regwrite_q;
  assign ex_aluop     = ex_aluop_q;
  assign ex_rd        = ex_rd_q;
  assign mem_valid    = mem_valid_q;
  assign mem_memread  = mem_memread_q;
  assign mem_memwrite = mem_memwrite_q;
  assign mem_regwrite = mem_regwrite_q;
  assign mem_memtoreg = mem_memtoreg_q;
  assign mem_rd       = mem_rd_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_rd        = wb_rd_q;
  assign stall_count  = stall_count_q;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation RV32 control unit for each core of the dual-core design.
- Decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles; squashes the ID-stage instruction on a taken branch or jump.
- Extends the decoded opcode set to BRANCH, JALR, LUI and AUIPC.

Parameters:
REG_ADDR_W, 5, register-index width for rd/rs1/rs2
ALUOP_W, 2, ALUOp width (minimum 2); decoded codes zero-extended
STALL_CNT_W, 16, width of the saturating load-use stall counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID-stage instruction valid
id_opcode  in  7  instr[6:0]
id_rd  in  REG_ADDR_W  destination register
id_rs1  in  REG_ADDR_W  source register 1
id_rs2  in  REG_ADDR_W  source register 2
flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
stall  out  1  load-use stall; hold PC and IF/ID (combinational)
ex_valid, ex_alusrc, ex_jump, ex_branch, ex_memread, ex_regwrite  out  1 each  EX-stage control
ex_aluop  out  ALUOP_W  EX ALU operation class
ex_rd  out  REG_ADDR_W  EX destination register
mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1 each  MEM-stage control
mem_rd  out  REG_ADDR_W  MEM destination register
wb_valid, wb_regwrite, wb_memtoreg  out  1 each  WB-stage control
wb_rd  out  REG_ADDR_W  WB destination register
stall_count  out  STALL_CNT_W  saturating count of stall cycles
illegal  out  1  sticky illegal-opcode flag (optional feature only; otherwise tied 0)

Behaviour:
- Decode is combinational in ID. Fields: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp, Jump, Branch, uses_rs1, uses_rs2.
  - 0110011 R: RegWrite, ALUOp=10, uses rs1 and rs2.
  - 0010011 I-ALU: RegWrite, ALUSrc, ALUOp=10, uses rs1.
  - 0000011 LW: RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00, uses rs1.
  - 0100011 SW: MemWrite, ALUSrc, ALUOp=00, uses rs1 and rs2.
  - 1100011 BRANCH: Branch, ALUOp=01, uses rs1 and rs2.
  - 1101111 JAL: RegWrite, Jump, ALUOp=00.
  - 1100111 JALR: RegWrite, Jump, ALUSrc, ALUOp=00, uses rs1.
  - 0110111 LUI: RegWrite, ALUSrc, ALUOp=11.
  - 0010111 AUIPC: RegWrite, ALUSrc, ALUOp=00.
  - Any other opcode: all fields 0 (a NOP).
- RegWrite is forced to 0 when id_rd==0.
- Load-use stall (combinational): stall = id_valid & ex_valid & ex_memread & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)) & !flush.
- ID/EX register update, per clock:
  - flush or stall: load a bubble (valid and all controls 0, rd=0).
  - otherwise: load the decoded bundle, with valid=id_valid; an invalid instruction loads all controls 0.
- EX/MEM and MEM/WB always advance; no backpressure. Latency is exactly 1 cycle per stage: WB control appears 3 cycles after ID.
- flush has priority over stall. flush does not affect EX/MEM or MEM/WB.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.
- Reset (asynchronous, active-high): all stage registers 0, stall_count=0, illegal=0. stall is 0 during reset because ex_valid=0. A reset mid-operation discards all in-flight instructions.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - A valid unrecognised opcode entering EX (not flushed, not stalled) sets illegal=1 on that edge; illegal stays set until rst.
  - The instruction still proceeds as a NOP.
- Undefined: illegal is tied 0; unrecognised opcodes are silent NOPs.

Test Plan:
- Reset then id_valid=1, opcode 0110011, rd=5 → after 1 clk ex_aluop=10, ex_regwrite=1; after 3 clk wb_regwrite=1, wb_rd=5, wb_memtoreg=0.
- LW rd=3 followed by ADD rs1=3 → stall=1 for exactly 1 cycle; next cycle ex_valid=0 (bubble); stall_count=1; ADD then reaches EX.
- LW rd=0 followed by ADD rs1=0 → stall=0 (x0 never hazards); LW reaches WB with wb_regwrite=0.
- Load-use condition with flush=1 in the same cycle → stall=0; next ex_valid=0; stall_count unchanged.
- JALR opcode 1100111, rd=1 → ex_jump=1, ex_alusrc=1; LUI → ex_aluop=11; BRANCH → ex_branch=1, ex_aluop=01, ex_regwrite=0.
- opcode 1111111 valid → all controls 0; illegal=1 one clk later with ILLEGAL_OPCODE_TRAP_EN, 0 without; assert rst mid-pipeline → all outputs 0 immediately.
